// File: rtl/vram_arbiter.sv
// Single-port video RAM scheduler: display fetch owns phase 0 of each pixel
// period while video is active; every other cycle is available to the CPU.
module vram_arbiter #(
  parameter int DW = 8,
  parameter int AW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_tick,
  input  logic [9:0]    pixelx,
  input  logic [9:0]    pixely,
  input  logic          video_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rgb,
  output logic          hsync_out,
  output logic          vsync_out
);

  localparam logic [AW-1:0] FRAME_WORDS = AW'(307200);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cpu_state_t;

  cpu_state_t    state;
  cpu_state_t    state_next;

  logic [1:0]    phase_q;
  logic [1:0]    phase;
  logic          display_slot;
  logic          grant;
  logic          out_of_range;
  logic [AW-1:0] disp_addr;

  logic          stage_video;
  logic          stage_hsync;
  logic          stage_vsync;
  logic          acc_read;
  logic          acc_oor;

  // pixel_tick always marks phase 0, so a drifted count heals on the next tick.
  assign phase = pixel_tick ? 2'd0 : phase_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase + 2'd1;
    end
  end

  // Row stride 640 = 512 + 128; result wraps to AW bits.
  assign disp_addr = (AW'(pixely) << 9) + (AW'(pixely) << 7) + AW'(pixelx);

  assign display_slot = reset && video_on && (phase == 2'd0);
  assign out_of_range = (cpu_addr >= FRAME_WORDS);

  // CPU handshake: cpu_req with cpu_we/cpu_addr/cpu_wdata is held stable by
  // the requester until the single-cycle cpu_ack, one clock after the grant.
  assign grant = reset && (state == IDLE) && cpu_req && !display_slot;

  // Sync stage is refreshed every phase 0, blanking included.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_video <= 1'b0;
      stage_hsync <= 1'b0;
      stage_vsync <= 1'b0;
    end else if (phase == 2'd0) begin
      stage_video <= video_on;
      stage_hsync <= hsync_in;
      stage_vsync <= vsync_in;
    end
  end

  // Display data arrives in phase 1, one cycle after the phase-0 fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (phase == 2'd1) begin
      rgb       <= stage_video ? ram_rdata : '0;
      hsync_out <= stage_hsync;
      vsync_out <= stage_vsync;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_read <= 1'b0;
      acc_oor  <= 1'b0;
    end else if (grant) begin
      acc_read <= !cpu_we;
      acc_oor  <= out_of_range;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant ? ACK : IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_ack   = 1'b0;
    cpu_rdata = '0;
    if (reset && (state == ACK)) begin
      cpu_ack = 1'b1;
      if (acc_read && !acc_oor) begin
        cpu_rdata = ram_rdata;
      end
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (display_slot) begin
      ram_addr = disp_addr;
    end else if (grant) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_we && !out_of_range;
      ram_wdata = cpu_wdata;
    end
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM scheduler between the 640x480 VGA sync generator and a CPU/drawing port. Each 4-clock pixel period is split into phase slots. Phase 0 is reserved for the display fetch while video is active. All other slots, and phase 0 during blanking, serve the CPU. Display data and the sync signals leave the block pipeline-aligned, ready for the RGB output register.

## Interface
- DW, 8, pixel/RAM data width
- AW, 19, RAM address width (640*480 = 307200 words)
- clk  in  1  system clock (4x pixel rate)
- reset  in  1  synchronous, active-low reset
- pixel_tick  in  1  one-cycle pulse from sync generator, once per 4 clocks
- pixelx, pixely  in  10 each  current pixel coordinates from sync generator
- video_on, hsync_in, vsync_in  in  1 each  from sync generator
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AW  word address; stable while cpu_req is high
- cpu_wdata  in  DW  write data; stable while cpu_req is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data, valid in the cpu_ack cycle
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, registered output, 1-cycle latency
- rgb  out  DW  pixel data for the current output pixel
- hsync_out, vsync_out  out  1 each  syncs delayed to align with rgb

## Operation
- Phase counter, 2 bits:
  - Cycle with pixel_tick=1 is phase 0; phase increments each clock and wraps 3->0.
  - Resynchronisation: pixel_tick=1 forces phase 0 regardless of the count.
- Display slot, phase 0 with video_on=1:
  - ram_addr = pixely*640 + pixelx, computed as (pixely<<9)+(pixely<<7)+pixelx truncated to AW; ram_we=0.
  - video_on, hsync_in and vsync_in are captured into a stage register in the same cycle.
- CPU slot: any cycle that is not a display slot.
- CPU FSM:
  - IDLE:
    - Grant when cpu_req=1 and the cycle is a CPU slot.
    - Drive ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata, then go to ACK.
  - ACK:
    - Pulse cpu_ack=1; on a read, cpu_rdata=ram_rdata.
    - Return to IDLE; no new grant in the ACK cycle.
    - Result: at most one CPU access per 2 clocks.
- Out-of-range cpu_addr (>= 307200):
  - Still granted and acked.
  - ram_we forced 0; cpu_rdata=0.
- A CPU request arriving during a display slot waits for the next CPU slot. Worst-case grant latency is 1 clock.
- When idle (no grant, no display fetch): ram_we=0, ram_addr=0, ram_wdata=0.
- The display slot always wins. A CPU grant never occurs in phase 0 while video_on=1.

## Timing
- Reset (reset=0 at a clk edge) forces:
  - phase=0, FSM=IDLE, stage register cleared
  - rgb=0, hsync_out=0, vsync_out=0, cpu_ack=0, cpu_rdata=0
  - ram_we=0, ram_addr=0, ram_wdata=0
- Reset mid-access:
  - Any pending ACK is dropped; no cpu_ack is issued.
  - The CPU must re-request after reset releases.
- Output pipeline:
  - Edge ending phase 1: rgb = ram_rdata if the stage video_on=1, else 0.
  - hsync_out and vsync_out take the stage values at the same edge.
  - Latency: 2 clocks after the pixel_tick cycle; all three outputs change together and hold for 4 clocks.
- Phase-0 blanking: hsync/vsync/video_on are captured every phase 0, including blanking cycles, so syncs stay aligned during blanking.
- CPU timing:
  - Write: grant cycle G has ram_we=1; cpu_ack at G+1.
  - Read: RAM address at G; cpu_ack and cpu_rdata at G+1.
- CPU read data returning in phase 1 never collides with display data. A display fetch issues only in phase 0, and its data returns in phase 1, when no CPU grant can have been made in phase 0 (display slot).
- Frame wrap: pixely=524 -> 0 needs no special handling. The address is only issued when video_on=1, so its maximum is 307199.

## Test plan
- Reset: hold reset=0 for 3 clocks with cpu_req=1 -> all outputs 0, no cpu_ack; release -> first grant in the first CPU slot.
- CPU write then read: write 0xA5 to address 1000 during blanking, then read it back -> ack 1 clock after each grant, cpu_rdata=0xA5.
- Display priority: cpu_req=1 asserted in phase 0 with video_on=1, pixelx=3, pixely=2:
  - ram_addr=1283 in phase 0, ram_we=0.
  - CPU granted in phase 1 and acked in phase 2.
- Pipeline alignment: preload address 641 with 0x3C; at pixelx=1, pixely=1 -> rgb=0x3C exactly 2 clocks after that pixel_tick, held 4 clocks, with hsync_out/vsync_out matching the values captured in that phase 0.
- Out-of-range: write to 307200 -> cpu_ack=1, ram_we stays 0; read of 400000 -> cpu_ack=1, cpu_rdata=0.
- Back-to-back CPU with cpu_req held high for 10 clocks during blanking -> exactly 5 acks, no grant in any ACK cycle.
